dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Sequences data-memory accesses for the MEM stage of the 5-stage MIPS pipeline. It takes the load/store control fields, ALU-computed address and store operand (PB) held in the EX/MEM pipeline register, and drives a variable-latency data memory over a req/ack handshake. It holds the pipeline with `stall` until the access completes. It also aligns and extends load data for MEM/WB, and flags misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 255, maximum ACCESS cycles spent waiting for mem_ack before aborting (must be >= 1)
CNT_W, 8, width of timeout counter (2^CNT_W > TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
mem_read  input  1  load in EX/MEM
mem_write  input  1  store in EX/MEM
mem_size  input  2  00 byte, 01 half, 10/11 word
mem_sign  input  1  1 = sign-extend loads, 0 = zero-extend
addr  input  32  byte address (EX/MEM alu_result)
wdata  input  32  store operand (EX/MEM PB)
mem_req  output  1  memory request, held until ack
mem_we  output  1  1 = write
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
mem_be  output  4  byte enables, bit n = byte lane addr[1:0]==n
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  memory completion, sampled only in ACCESS
mem_rdata  input  32  read word, valid with mem_ack
stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
load_data  output  32  aligned, extended load result
load_valid  output  1  one-cycle pulse, load_data valid
misalign_exc  output  1  one-cycle pulse, misaligned access
illegal_exc  output  1  one-cycle pulse, read and write both set
timeout_exc  output  1  one-cycle pulse, ack timeout

Behaviour:
- Reset: state=IDLE; mem_req, mem_we, mem_addr, mem_be, mem_wdata, load_data, load_valid, all exc outputs, counter = 0. stall is 0 during and after reset. Reset in any state aborts the access; mem_req is 0 the next cycle.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - mem_read^mem_write, aligned: stall=1 combinationally. Capture we, mem_addr, mem_be, mem_wdata, size, sign and addr[1:0]. Go to ACCESS.
  - Both read and write set: illegal_exc pulses next cycle. No request, stall=0.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0): misalign_exc pulses next cycle. No request, stall=0.
  - No request: stall=0.
- ACCESS:
  - mem_req=1 and stall=1 throughout. Request fields are stable until exit. Counter clears on entry and increments each cycle without ack.
  - mem_ack=1 at a posedge: go to DONE. For loads, capture mem_rdata.
  - Count reaches TIMEOUT_CYCLES-1 with no ack: go to DONE, timeout_exc pulses, load_valid=0, load_data=0.
  - Ack on the final allowed cycle wins over timeout.
- DONE: lasts one cycle. mem_req=0, stall=0, so EX/MEM and MEM/WB advance. load_valid=1 for a completed load only. Request inputs are ignored. Go to IDLE.
- Latency: aligned access with ack in ACCESS cycle k (k>=1) gives stall high for k+1 cycles. DONE follows.
- mem_ack outside ACCESS is ignored.
- Byte enables:
  - byte: one-hot at addr[1:0]
  - half: 0011 (addr[1]=0) or 1100 (addr[1]=1)
  - word: 1111
  - Loads drive the same mem_be.
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
  - Loads drive mem_wdata=0.
- Load extraction:
  - byte: mem_rdata[8*a+7:8*a], a=addr[1:0]
  - half: mem_rdata[16*h+15:16*h], h=addr[1]
  - Result is extended to 32 bits per mem_sign.
- Little-endian lane numbering.

Test Plan:
1. Word load addr 0x00000100; ack in 3rd ACCESS cycle, rdata 0xDEADBEEF -> stall high 4 cycles, mem_be=1111, mem_addr=0x100; DONE: load_valid=1, load_data=0xDEADBEEF.
2. Byte store addr 0x00000203, wdata 0x000000A5, ack in 1st ACCESS cycle -> mem_we=1, mem_be=1000, mem_addr=0x200, mem_wdata=0xA5A5A5A5, load_valid never 1, stall high 2 cycles.
3. Half load addr 0x102, mem_sign=1, rdata 0x80011234 -> load_data=0xFFFF8001. Repeat with mem_sign=0 -> 0x00008001. Byte load addr 0x100, sign=1, rdata 0x000000F0 -> 0xFFFFFFF0.
4. Word load addr 0x101 -> misalign_exc one pulse, mem_req never 1, stall 0. read=write=1 -> illegal_exc pulse, no request.
5. TIMEOUT_CYCLES=4, load with no ack -> exactly 4 ACCESS cycles with mem_req=1; then timeout_exc pulse, load_valid=0, stall 0, back to IDLE. Ack on 4th cycle -> normal completion, no timeout_exc.
6. Reset asserted in 2nd ACCESS cycle -> next cycle mem_req=0, stall=0, state IDLE. Late mem_ack after reset is ignored.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory sequencer; ports: clk/reset, EX/MEM request (mem_read, mem_write, mem_size, mem_sign, addr, wdata), memory req/ack bus (mem_req..mem_rdata), pipeline stall, aligned load_data/load_valid, misalign/illegal/timeout pulses
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_exc,
  output logic        illegal_exc,
  output logic        timeout_exc
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0] size_q, lane_q;
  logic sign_q, both, one, misal, start, last;
  logic [3:0] be_c;
  logic [31:0] wd_c, ld_c;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  always_comb begin
    both = mem_read & mem_write;
    one = mem_read ^ mem_write;
    misal = (mem_size == 2'b01 && addr[0]) || (mem_size[1] && addr[1:0] != 2'b00);
    start = one & ~misal;
    last = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    be_c = mem_size[1] ? 4'hF : mem_size[0] ? (addr[1] ? 4'hC : 4'h3) : 4'b0001 << addr[1:0];
    wd_c = mem_size[1] ? wdata : mem_size[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    byte_v = mem_rdata[{lane_q, 3'b000} +: 8];
    half_v = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_c = size_q[1] ? mem_rdata : size_q[0] ? {{16{sign_q & half_v[15]}}, half_v} : {{24{sign_q & byte_v[7]}}, byte_v};
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = (state == IDLE) ? (start ? ACCESS : IDLE) : (state == ACCESS) ? ((mem_ack | last) ? DONE : ACCESS) : IDLE;
  end
  always_comb begin
    mem_req = state == ACCESS;
    stall = ~reset & ((state == IDLE & start) | state == ACCESS);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
      size_q <= '0;
      lane_q <= '0;
      sign_q <= 1'b0;
      cnt <= '0;
      load_data <= '0;
      load_valid <= 1'b0;
      misalign_exc <= 1'b0;
      illegal_exc <= 1'b0;
      timeout_exc <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      misalign_exc <= 1'b0;
      illegal_exc <= 1'b0;
      timeout_exc <= 1'b0;
      if (state == IDLE) begin
        illegal_exc <= both;
        misalign_exc <= one & misal;
        if (start) begin
          mem_we <= mem_write;
          mem_addr <= {addr[31:2], 2'b00};
          mem_be <= be_c;
          mem_wdata <= mem_write ? wd_c : '0;
          size_q <= mem_size;
          lane_q <= addr[1:0];
          sign_q <= mem_sign;
          cnt <= '0;
        end
      end
      if (state == ACCESS) begin
        if (mem_ack) begin
          if (!mem_we) begin
            load_valid <= 1'b1;
            load_data <= ld_c;
          end
        end else if (last) begin
          timeout_exc <= 1'b1;
          load_data <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench with directed vectors for dmem_access_ctrl
module tb_dmem_access_ctrl;
  logic clk = 0, reset = 1;
  logic mem_read = 0, mem_write = 0, mem_sign = 0, mem_ack = 0;
  logic [1:0] mem_size = 0;
  logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
  logic mem_req, mem_we, stall, load_valid, misalign_exc, illegal_exc, timeout_exc;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0] mem_be;
  int passes = 0, total = 0, stlc = 0, reqc = 0;
  typedef struct {
    bit resp;
    logic we;
    logic [31:0] addr;
    logic [3:0] be;
    logic [31:0] wd;
    logic lv;
    logic [31:0] ld;
    logic mis, ill, to;
    int reqc, stlc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic ackev, respev;
  dmem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_sign(mem_sign), .addr(addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .load_data(load_data), .load_valid(load_valid), .misalign_exc(misalign_exc),
    .illegal_exc(illegal_exc), .timeout_exc(timeout_exc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic push_ack(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input int stl);
    exp_t x;
    x = '{resp: 0, we: we, addr: a, be: be, wd: wd, lv: 0, ld: 0, mis: 0, ill: 0, to: 0, reqc: 0, stlc: stl};
    q.push_back(x);
  endtask
  task automatic push_resp(input logic lv, input logic [31:0] ld, input logic mis, input logic ill, input logic to, input int rq, input int stl);
    exp_t x;
    x = '{resp: 1, we: 0, addr: 0, be: 0, wd: 0, lv: lv, ld: ld, mis: mis, ill: ill, to: to, reqc: rq, stlc: stl};
    q.push_back(x);
  endtask
  always @(negedge clk) begin
    if (stall) stlc++;
    if (mem_req) reqc++;
    ackev = mem_req && mem_ack;
    respev = load_valid || misalign_exc || illegal_exc || timeout_exc;
    if (ackev || respev) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_event: got ack=%b resp=%b expected none", ackev, respev);
      end else begin
        e = q.pop_front();
        chk("event_kind", {31'b0, respev}, {31'b0, e.resp});
        if (!e.resp) begin
          chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_be", {28'b0, mem_be}, {28'b0, e.be});
          chk("mem_wdata", mem_wdata, e.wd);
          chk("stall_cycles", stlc, e.stlc);
        end else begin
          chk("load_valid", {31'b0, load_valid}, {31'b0, e.lv});
          chk("misalign_exc", {31'b0, misalign_exc}, {31'b0, e.mis});
          chk("illegal_exc", {31'b0, illegal_exc}, {31'b0, e.ill});
          chk("timeout_exc", {31'b0, timeout_exc}, {31'b0, e.to});
          chk("req_cycles", reqc, e.reqc);
          chk("resp_stall_cycles", stlc, e.stlc);
          if (e.lv || e.to) chk("load_data", load_data, e.ld);
        end
      end
    end
    if (!stall && !mem_req) begin
      stlc = 0;
      reqc = 0;
    end
  end
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int k, input logic [31:0] rdt);
    mem_read = rd; mem_write = wr; mem_size = sz; mem_sign = sg; addr = a; wdata = wd;
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
    if (!mem_req) begin
      @(posedge clk); #1;
      return;
    end
    if (k > 0) begin
      repeat (k - 1) begin @(posedge clk); #1; end
      mem_ack = 1; mem_rdata = rdt;
      @(posedge clk); #1;
      mem_ack = 0;
    end else begin
      for (int n = 0; n < 50 && mem_req; n++) begin @(posedge clk); #1; end
      chk("ack_wait_bound", {31'b0, mem_req}, 32'd0);
    end
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    mem_read = 1; mem_size = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_load_valid", {31'b0, load_valid}, 32'd0);
    chk("rst_excs", {29'b0, misalign_exc, illegal_exc, timeout_exc}, 32'd0);
    mem_read = 0; reset = 0;
    @(posedge clk); #1;
    push_ack(0, 32'h100, 4'hF, 32'h0, 4);
    push_resp(1, 32'hDEADBEEF, 0, 0, 0, 3, 4);
    access(1, 0, 2'b10, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    push_ack(1, 32'h200, 4'b1000, 32'hA5A5A5A5, 2);
    access(0, 1, 2'b00, 0, 32'h203, 32'h000000A5, 1, 32'h0);
    push_ack(0, 32'h100, 4'b1100, 32'h0, 2);
    push_resp(1, 32'hFFFF8001, 0, 0, 0, 1, 2);
    access(1, 0, 2'b01, 1, 32'h102, 32'h0, 1, 32'h80011234);
    push_ack(0, 32'h100, 4'b1100, 32'h0, 2);
    push_resp(1, 32'h00008001, 0, 0, 0, 1, 2);
    access(1, 0, 2'b01, 0, 32'h102, 32'h0, 1, 32'h80011234);
    push_ack(0, 32'h100, 4'b0001, 32'h0, 2);
    push_resp(1, 32'hFFFFFFF0, 0, 0, 0, 1, 2);
    access(1, 0, 2'b00, 1, 32'h100, 32'h0, 1, 32'h000000F0);
    push_ack(0, 32'h100, 4'b0010, 32'h0, 3);
    push_resp(1, 32'h000000AB, 0, 0, 0, 2, 3);
    access(1, 0, 2'b00, 0, 32'h101, 32'h0, 2, 32'h0000AB00);
    push_ack(1, 32'h104, 4'b1100, 32'hBEEFBEEF, 2);
    access(0, 1, 2'b01, 0, 32'h106, 32'h1234BEEF, 1, 32'h0);
    push_ack(1, 32'h300, 4'hF, 32'h12345678, 3);
    access(0, 1, 2'b11, 0, 32'h300, 32'h12345678, 2, 32'h0);
    push_resp(0, 32'h0, 1, 0, 0, 0, 0);
    access(1, 0, 2'b10, 0, 32'h101, 32'h0, 1, 32'h0);
    push_resp(0, 32'h0, 1, 0, 0, 0, 0);
    access(1, 0, 2'b01, 0, 32'h103, 32'h0, 1, 32'h0);
    push_resp(0, 32'h0, 0, 1, 0, 0, 0);
    access(1, 1, 2'b10, 0, 32'h100, 32'h0, 1, 32'h0);
    push_resp(0, 32'h0, 0, 0, 1, 4, 5);
    access(1, 0, 2'b10, 0, 32'h400, 32'h0, 0, 32'h0);
    push_ack(0, 32'h400, 4'hF, 32'h0, 5);
    push_resp(1, 32'h55AA55AA, 0, 0, 0, 4, 5);
    access(1, 0, 2'b10, 0, 32'h400, 32'h0, 4, 32'h55AA55AA);
    mem_read = 1; mem_size = 2'b10; addr = 32'h500;
    @(posedge clk); #1;
    mem_read = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    chk("reset_abort_req", {31'b0, mem_req}, 32'd0);
    chk("reset_abort_stall", {31'b0, stall}, 32'd0);
    reset = 0; mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    repeat (3) begin
      @(posedge clk); #1;
      chk("late_ack_req", {31'b0, mem_req}, 32'd0);
      chk("late_ack_lv", {31'b0, load_valid}, 32'd0);
    end
    mem_ack = 0;
    push_ack(0, 32'h600, 4'hF, 32'h0, 2);
    push_resp(1, 32'h0BADF00D, 0, 0, 0, 1, 2);
    access(1, 0, 2'b10, 0, 32'h600, 32'h0, 1, 32'h0BADF00D);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
